// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4-Lite memory slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   rd_state_e              : read-channel FSM states
//   wr_state_e              : write-channel FSM states
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COLLECT,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_mem_array.sv
// DEPTH x 32 RAM with one synchronous write port and one synchronous read port.
// A read and a write to the same word on the same edge return the old data.
// Contents are not reset; only the read-data register is.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i       : read enable / address; rdata_o updates only when re_i
//   rdata_o            : registered read data
module axi_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite single-beat slave backed by a word-addressed 32-bit RAM.
// Independent read (AR/R) and write (AW/W/B) FSMs share one RAM.
// Optional feature macro: AXI_MEM_ERR_RESP_EN adds axi_rresp/axi_bresp and
// answers out-of-range addresses with SLVERR (no write, zero read data);
// without it, out-of-range addresses alias modulo DEPTH.
//   clk, rst_n                          : clock, async active-low reset
//   axi_araddr/arvalid/arready          : read address channel
//   axi_rdata/rvalid/rready             : read data channel
//   axi_awaddr/awvalid/awready          : write address channel
//   axi_wdata/wvalid/wready             : write data channel
//   axi_bvalid/bready                   : write response channel
//   axi_rresp/bresp (macro only)        : response codes
module axi_lite_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic        axi_bvalid,
  input  logic        axi_bready
`ifdef AXI_MEM_ERR_RESP_EN
  ,
  output logic [1:0]  axi_rresp,
  output logic [1:0]  axi_bresp
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'(READ_LATENCY - 1);

  // Address decode: byte offset from BASE_ADDR, word index in bits [AW+1:2].
  logic [31:0]   ar_off, aw_off;
  logic [AW-1:0] ar_idx, aw_idx;
  logic          ar_err, aw_err;
  logic          unused_addr_bits;

  assign ar_off = axi_araddr - BASE_ADDR;
  assign aw_off = axi_awaddr - BASE_ADDR;
  assign ar_idx = ar_off[AW+1:2];
  assign aw_idx = aw_off[AW+1:2];
  assign unused_addr_bits = ^{ar_off, aw_off};

`ifdef AXI_MEM_ERR_RESP_EN
  // Offset wraps below BASE_ADDR, so one unsigned bound check covers both ends.
  assign ar_err = (ar_off >> (AW + 2)) != '0;
  assign aw_err = (aw_off >> (AW + 2)) != '0;
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  // ---------------- Read channel ----------------
  rd_state_e     r_state_q;
  logic          arready_q, rvalid_q, r_err_q;
  logic [AW-1:0] r_idx_q;
  logic [3:0]    r_cnt_q;
  logic          ar_hs, ram_re;
  logic [31:0]   ram_rdata;
`ifdef AXI_MEM_ERR_RESP_EN
  logic [1:0]    rresp_q;
`endif

  assign ar_hs  = axi_arvalid && arready_q;
  assign ram_re = (r_state_q == R_WAIT) && (r_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      r_err_q   <= 1'b0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
`ifdef AXI_MEM_ERR_RESP_EN
      rresp_q   <= RESP_OKAY;
`endif
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= !ar_hs;
          if (ar_hs) begin
            r_idx_q   <= ar_idx;
            r_err_q   <= ar_err;
            r_cnt_q   <= LAT_M1;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt_q == '0) begin
            rvalid_q  <= 1'b1;
`ifdef AXI_MEM_ERR_RESP_EN
            rresp_q   <= r_err_q ? RESP_SLVERR : RESP_OKAY;
`endif
            r_state_q <= R_DATA;
          end else begin
            r_cnt_q <= r_cnt_q - 4'd1;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = r_err_q ? '0 : ram_rdata;

  // ---------------- Write channel ----------------
  wr_state_e     w_state_q;
  logic          awready_q, wready_q, bvalid_q;
  logic          aw_have_q, w_have_q, aw_err_q;
  logic [AW-1:0] aw_idx_q;
  logic [31:0]   wdata_q;
  logic          aw_hs, w_hs, commit, wr_err, ram_we;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
`ifdef AXI_MEM_ERR_RESP_EN
  logic [1:0]    bresp_q;
`endif

  assign aw_hs = axi_awvalid && awready_q;
  assign w_hs  = axi_wvalid && wready_q;

  // Commit on the edge where the second of AW/W arrives (or both together);
  // the half arriving on this edge bypasses its capture register.
  assign commit  = (w_state_q != W_RESP) && (aw_have_q || aw_hs) && (w_have_q || w_hs);
  assign wr_idx  = aw_have_q ? aw_idx_q : aw_idx;
  assign wr_err  = aw_have_q ? aw_err_q : aw_err;
  assign wr_data = w_have_q ? wdata_q : axi_wdata;
  assign ram_we  = commit && !wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_err_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
`ifdef AXI_MEM_ERR_RESP_EN
      bresp_q   <= RESP_OKAY;
`endif
    end else begin
      case (w_state_q)
        W_IDLE, W_COLLECT: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            aw_have_q <= 1'b1;
            aw_idx_q  <= aw_idx;
            aw_err_q  <= aw_err;
          end else if (w_state_q == W_IDLE) begin
            awready_q <= 1'b1;
          end
          if (w_hs) begin
            wready_q <= 1'b0;
            w_have_q <= 1'b1;
            wdata_q  <= axi_wdata;
          end else if (w_state_q == W_IDLE) begin
            wready_q <= 1'b1;
          end
          if (commit) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bvalid_q  <= 1'b1;
`ifdef AXI_MEM_ERR_RESP_EN
            bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
`endif
            w_state_q <= W_RESP;
          end else if (aw_hs || w_hs) begin
            w_state_q <= W_COLLECT;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;

`ifdef AXI_MEM_ERR_RESP_EN
  assign axi_rresp = rresp_q;
  assign axi_bresp = bresp_q;
`endif

  axi_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (r_idx_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
module tb_axi_lite_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp_v, bresp_v;

  // Second instance for the READ_LATENCY = 4 check.
  logic [31:0] a4_araddr = '0, zero32 = '0;
  logic        a4_arvalid = 0, a4_rready = 0, zero1 = 0;
  logic        a4_arready, a4_rvalid;
  logic [31:0] a4_unused_rdata;
  logic        a4_unused_awready, a4_unused_wready, a4_unused_bvalid;

`ifdef AXI_MEM_ERR_RESP_EN
  logic [1:0] rresp, bresp, a4_unused_rresp, a4_unused_bresp;
  assign rresp_v = rresp;
  assign bresp_v = bresp;
`else
  assign rresp_v = 2'b00;
  assign bresp_v = 2'b00;
`endif

  axi_lite_mem_slave #(.DEPTH(1024), .READ_LATENCY(1), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rvalid(rvalid), .axi_rready(rready),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bvalid(bvalid), .axi_bready(bready)
`ifdef AXI_MEM_ERR_RESP_EN
    , .axi_rresp(rresp), .axi_bresp(bresp)
`endif
  );

  axi_lite_mem_slave #(.DEPTH(1024), .READ_LATENCY(4), .BASE_ADDR(32'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .axi_araddr(a4_araddr), .axi_arvalid(a4_arvalid), .axi_arready(a4_arready),
    .axi_rdata(a4_unused_rdata), .axi_rvalid(a4_rvalid), .axi_rready(a4_rready),
    .axi_awaddr(zero32), .axi_awvalid(zero1), .axi_awready(a4_unused_awready),
    .axi_wdata(zero32), .axi_wvalid(zero1), .axi_wready(a4_unused_wready),
    .axi_bvalid(a4_unused_bvalid), .axi_bready(zero1)
`ifdef AXI_MEM_ERR_RESP_EN
    , .axi_rresp(a4_unused_rresp), .axi_bresp(a4_unused_bresp)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];          // expected read data, pushed at issue
  logic [31:0] model [int];       // reference memory by word index

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output bit to, output logic [1:0] resp);
    int n;
    to = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    if (n >= 20) to = 1;
    step();
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    if (!bvalid) to = 1;
    resp = bresp_v;
    bready = 1; step(); bready = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output int lat, output bit to, output logic [1:0] resp);
    int n;
    to = 0;
    araddr = a; arvalid = 1;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    if (n >= 20) to = 1;
    step();
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 40) begin step(); lat++; end
    if (!rvalid) to = 1;
    d = rdata; resp = rresp_v;
    rready = 1; step(); rready = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {arready, awready, wready, rvalid, bvalid}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
`ifdef AXI_MEM_ERR_RESP_EN
    total++; if ({rresp, bresp} !== 4'b0) begin bad++; $display("FAIL reset_resp got=%b exp=0000", {rresp, bresp}); end
`endif
    @(posedge clk); #1; rst_n = 1;
    total++; if ({arready, awready, wready} !== 3'b000) begin bad++; $display("FAIL ready_at_release got=%b exp=000", {arready, awready, wready}); end
    step();
    total++; if ({arready, awready, wready} !== 3'b111) begin bad++; $display("FAIL ready_after_release got=%b exp=111", {arready, awready, wready}); end
  endtask

  task automatic test_basic();
    logic [31:0] d, e; int lat; bit to; logic [1:0] resp;
    awaddr = 32'h10; wdata = 32'hDEADBEEF; awvalid = 1; wvalid = 1;
    total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL basic_wr_ready got=%b exp=11", {awready, wready}); end
    step();
    awvalid = 0; wvalid = 0;
    total++; if ({bvalid, awready, wready} !== 3'b100) begin bad++; $display("FAIL basic_bvalid got=%b exp=100", {bvalid, awready, wready}); end
    bready = 1; step(); bready = 0;
    total++; if ({bvalid, awready, wready} !== 3'b011) begin bad++; $display("FAIL basic_b_done got=%b exp=011", {bvalid, awready, wready}); end
    model[4] = 32'hDEADBEEF;
    exp_q.push_back(model[4]);
    rd(32'h10, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL basic_rd_timeout got=1 exp=0"); end
    total++; if (lat !== 1) begin bad++; $display("FAIL basic_rd_latency got=%0d exp=1", lat); end
    total++; if (d !== e) begin bad++; $display("FAIL basic_rdata got=%h exp=%h", d, e); end
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL basic_rresp got=%b exp=00", resp); end
  endtask

  task automatic test_aw_w_order();
    logic [31:0] d, e; int lat; bit to; logic [1:0] resp;
    for (int mode = 0; mode < 3; mode++) begin
      wr(32'h20, 32'h0, to, resp);
      if (mode == 0) begin
        wdata = 32'h12345678; wvalid = 1; step(); wvalid = 0;
        total++; if ({wready, awready} !== 2'b01) begin bad++; $display("FAIL order_w_first_ready got=%b exp=01", {wready, awready}); end
        step(); step();
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL order_w_first_nob got=%b exp=0", bvalid); end
        awaddr = 32'h20; awvalid = 1; step(); awvalid = 0;
      end else if (mode == 1) begin
        awaddr = 32'h20; awvalid = 1; step(); awvalid = 0;
        total++; if ({awready, wready} !== 2'b01) begin bad++; $display("FAIL order_aw_first_ready got=%b exp=01", {awready, wready}); end
        step(); step();
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL order_aw_first_nob got=%b exp=0", bvalid); end
        wdata = 32'h12345678; wvalid = 1; step(); wvalid = 0;
      end else begin
        awaddr = 32'h20; wdata = 32'h12345678; awvalid = 1; wvalid = 1; step();
        awvalid = 0; wvalid = 0;
      end
      total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL order_bvalid mode=%0d got=%b exp=1", mode, bvalid); end
      bready = 1; step(); bready = 0;
      model[8] = 32'h12345678;
      exp_q.push_back(model[8]);
      rd(32'h20, d, lat, to, resp);
      e = exp_q.pop_front();
      total++; if (to || d !== e) begin bad++; $display("FAIL order_rdata mode=%0d got=%h exp=%h", mode, d, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e; int n;
    exp_q.push_back(model[4]);
    araddr = 32'h10; arvalid = 1; step(); arvalid = 0;
    n = 0;
    while (!rvalid && n < 40) begin step(); n++; end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++; if ({rvalid, arready} !== 2'b10 || rdata !== e) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=10/%h", i, {rvalid, arready}, rdata, e); end
      step();
    end
    rready = 1; step(); rready = 0;
    total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", {rvalid, arready}); end
  endtask

  task automatic test_collision();
    logic [31:0] d, e; int lat; bit to; logic [1:0] resp;
    wr(32'h40, 32'h0, to, resp);
    model[16] = 32'h0;
    exp_q.push_back(model[16]);
    araddr = 32'h40; arvalid = 1; step(); arvalid = 0;
    awaddr = 32'h40; wdata = 32'hA5A5A5A5; awvalid = 1; wvalid = 1; step();
    awvalid = 0; wvalid = 0;
    model[16] = 32'hA5A5A5A5;
    e = exp_q.pop_front();
    total++; if (rvalid !== 1'b1 || rdata !== e) begin bad++; $display("FAIL coll_old got=%b/%h exp=1/%h", rvalid, rdata, e); end
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL coll_bvalid got=%b exp=1", bvalid); end
    rready = 1; bready = 1; step(); rready = 0; bready = 0;
    exp_q.push_back(model[16]);
    rd(32'h40, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e) begin bad++; $display("FAIL coll_new got=%h exp=%h", d, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e; int lat; bit to; logic [1:0] resp;
    wr(32'h1010, 32'h5555AAAA, to, resp);
`ifdef AXI_MEM_ERR_RESP_EN
    total++; if (to || resp !== 2'b10) begin bad++; $display("FAIL err_bresp got=%b exp=10", resp); end
    exp_q.push_back(model[4]);
    rd(32'h10, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e || resp !== 2'b00) begin bad++; $display("FAIL err_unchanged got=%h/%b exp=%h/00", d, resp, e); end
    exp_q.push_back(32'h0);
    rd(32'h1010, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e || resp !== 2'b10) begin bad++; $display("FAIL err_rd got=%h/%b exp=%h/10", d, resp, e); end
`else
    total++; if (to) begin bad++; $display("FAIL wrap_wr_timeout got=1 exp=0"); end
    model[4] = 32'h5555AAAA;
    exp_q.push_back(model[4]);
    rd(32'h10, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e) begin bad++; $display("FAIL wrap_alias got=%h exp=%h", d, e); end
    exp_q.push_back(model[4]);
    rd(32'h1010, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e) begin bad++; $display("FAIL wrap_high got=%h exp=%h", d, e); end
`endif
  endtask

  task automatic test_latency4();
    int n;
    a4_araddr = 32'h0; a4_arvalid = 1;
    n = 0;
    while (!a4_arready && n < 20) begin step(); n++; end
    step(); a4_arvalid = 0;
    n = 0;
    while (!a4_rvalid && n < 40) begin step(); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL lat4 got=%0d exp=4", n); end
    a4_rready = 1; step(); a4_rready = 0;
    total++; if ({a4_rvalid, a4_arready} !== 2'b01) begin bad++; $display("FAIL lat4_done got=%b exp=01", {a4_rvalid, a4_arready}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e; int lat; bit to; logic [1:0] resp;
    wr(32'h80, 32'h11111111, to, resp);
    model[32] = 32'h11111111;
    araddr = 32'h10; arvalid = 1;
    awaddr = 32'h80; awvalid = 1; wdata = 32'h22222222;
    step();
    arvalid = 0; awvalid = 0;
    rst_n = 0; #1;
    total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || rdata !== 32'h0) begin bad++; $display("FAIL mid_reset_outs got=%b/%h exp=00000/0", {arready, awready, wready, rvalid, bvalid}, rdata); end
    @(posedge clk); #1; rst_n = 1;
    step();
    total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin bad++; $display("FAIL mid_after_release got=%b exp=11100", {arready, awready, wready, rvalid, bvalid}); end
    for (int i = 0; i < 4; i++) begin
      total++; if ({rvalid, bvalid} !== 2'b00) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b exp=00", i, {rvalid, bvalid}); end
      step();
    end
    exp_q.push_back(model[32]);
    rd(32'h80, d, lat, to, resp);
    e = exp_q.pop_front();
    total++; if (to || d !== e) begin bad++; $display("FAIL mid_aborted_write got=%h exp=%h", d, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_aw_w_order();
    test_backpressure();
    test_collision();
    test_wrap();
    test_latency4();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
